amo_sequencer: RTL

AMO_SEQUENCER -- requirements
Module: amo_sequencer

---
 rtl/amo_sequencer_if.sv | 53 +++++
 rtl/amo_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/amo_sequencer_if.sv
// Bus bundle for the AMO sequencer: request, memory read/write, ALU and
// response channels. 'slave' is the sequencer's view, 'master' is the
// view of the surrounding core/memory/ALU.
interface amo_sequencer_if #(
  parameter int ID_WIDTH = 2
);
  // request channel
  logic                req_valid;
  logic                req_ready;
  logic [4:0]          req_op;
  logic [31:0]         req_addr;
  logic [31:0]         req_rs2;
  logic [ID_WIDTH-1:0] req_id;
  // memory read request / data return
  logic                mem_rd_valid;
  logic                mem_rd_ready;
  logic [31:0]         mem_addr;
  logic                mem_rdata_valid;
  logic [31:0]         mem_rdata;
  // memory write request (to mem_addr)
  logic                mem_wr_valid;
  logic                mem_wr_ready;
  logic [31:0]         mem_wr_data;
  // external combinational AMO ALU
  logic [4:0]          alu_op;
  logic [31:0]         alu_rs1_load;
  logic [31:0]         alu_rs2;
  logic [31:0]         alu_result;
  // response channel
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [ID_WIDTH-1:0] rsp_id;
  logic                rsp_err;

  modport slave (
    input  req_valid, req_op, req_addr, req_rs2, req_id,
    input  mem_rd_ready, mem_rdata_valid, mem_rdata, mem_wr_ready,
    input  alu_result, rsp_ready,
    output req_ready, mem_rd_valid, mem_addr, mem_wr_valid, mem_wr_data,
    output alu_op, alu_rs1_load, alu_rs2,
    output rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport master (
    output req_valid, req_op, req_addr, req_rs2, req_id,
    output mem_rd_ready, mem_rdata_valid, mem_rdata, mem_wr_ready,
    output alu_result, rsp_ready,
    input  req_ready, mem_rd_valid, mem_addr, mem_wr_valid, mem_wr_data,
    input  alu_op, alu_rs1_load, alu_rs2,
    input  rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/amo_sequencer.sv
// Single-outstanding atomic memory operation sequencer.
// Reads the target word, lets an external combinational ALU compute the
// new value, writes it back, then returns the original word with the tag.
// Unsupported fn5 codes skip the write and respond with an error flag.
module amo_sequencer #(
  parameter int ID_WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  amo_sequencer_if.slave    bus,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]          r_state;
  logic [4:0]          r_op;
  logic [31:0]         r_addr;
  logic [31:0]         r_rs2;
  logic [ID_WIDTH-1:0] r_id;
  logic [31:0]         r_load;
  logic                r_err;
  logic                w_supported;

  // Decode whether the captured fn5 is an AMO this sequencer can perform.
  // LR/SC share the AMO opcode space but are not read-modify-write ops.
  always_comb begin
    case (r_op)
      5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
      5'b10000, 5'b10100, 5'b11000, 5'b11100: w_supported = 1'b1;
      default:                                w_supported = 1'b0;
    endcase
  end

  // Main sequencing FSM plus all captured state. Captured registers only
  // change on request accept (IDLE) and on data return (WAIT), so every
  // output derived from them is stable while its valid waits for ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_rs2   <= '0;
      r_id    <= '0;
      r_load  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_rs2   <= bus.req_rs2;
            r_id    <= bus.req_id;
            r_load  <= '0;
            r_err   <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // read data arriving alongside the read handshake is ignored
          if (bus.mem_rd_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rdata_valid) begin
            r_load <= bus.mem_rdata;
            if (w_supported) begin
              r_state <= S_WRITE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_wr_ready) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and data outputs decoded from state and captured registers.
  always_comb begin
    bus.req_ready    = (r_state == S_IDLE);
    bus.mem_rd_valid = (r_state == S_READ);
    bus.mem_wr_valid = (r_state == S_WRITE);
    bus.rsp_valid    = (r_state == S_RESP);
    bus.mem_addr     = r_addr;
    bus.mem_wr_data  = bus.alu_result;
    bus.alu_op       = r_op;
    bus.alu_rs1_load = r_load;
    bus.alu_rs2      = r_rs2;
    bus.rsp_data     = r_load;
    bus.rsp_id       = r_id;
    bus.rsp_err      = r_err;
    busy             = (r_state != S_IDLE);
  end

endmodule
